// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter family:
//   - parity-mode constants (PAR_NONE / PAR_ODD / PAR_EVEN)
//   - serialiser state encoding
//   - cfg_ok(): legality check applied to every parameter set at elaboration
//   - parity_of(): parity bit for a payload (unused high bits must be zero)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // True when the parameter set describes a buildable transmitter.
  function automatic bit cfg_ok(input int baud_div,
                                input int data_bits,
                                input int parity,
                                input int stop_bits,
                                input int fifo_depth);
    bit ok;
    ok = (baud_div >= 2) &&
         (data_bits >= 5) && (data_bits <= 9) &&
         (parity >= PAR_NONE) && (parity <= PAR_EVEN) &&
         ((stop_bits == 1) || (stop_bits == 2)) &&
         (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0);
    return ok;
  endfunction

  // Odd mode makes data+parity contain an odd number of ones, even mode an
  // even number. Zero-padding above the payload does not change the result.
  function automatic logic parity_of(input logic [8:0] d, input int mode);
    logic p;
    p = 1'b0;
    case (mode)
      PAR_ODD:  p = ~(^d);
      PAR_EVEN: p = ^d;
      default:  p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO feeding the UART serialiser. First-word fall-through:
// dout always shows the head entry, pop consumes it at the clock edge.
// Pushes while full and pops while empty are ignored. full/empty are
// registered so the transmitter's ready/empty outputs come straight from flops.
//
// Parameters: WIDTH (entry width), DEPTH (entries, power of 2, >= 2)
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write strobe and data
//   pop, dout  read strobe and head data
//   full       no free entries
//   empty      no stored entries
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             full_q;
  logic             empty_q;
  logic             do_push;
  logic             do_pop;

  // Acceptance looks only at the registered full flag, so a pop on the same
  // edge never makes room for a push that arrived while full.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      full_q  <= (count_nxt == CNT_W'(DEPTH));
      empty_q <= (count_nxt == '0);
    end
  end

  // Storage carries data only; it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_tx_ext.sv
// -----------------------------------------------------------------------------
// uart_tx_ext
// UART transmitter with an input FIFO, configurable payload length, parity
// and stop bits. Characters queued in the FIFO are sent back to back: the
// next start bit follows the last stop-bit cycle with no idle gap.
//
// Parameters:
//   BAUD_DIV   clk cycles per bit (>= 2)
//   DATA_BITS  payload bits per frame (5..9)
//   PARITY     0 none, 1 odd, 2 even (3 rejected at elaboration)
//   STOP_BITS  1 or 2
//   FIFO_DEPTH entries, power of 2, >= 2
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   go, data   push strobe and character (one cycle per character)
//   tx         serial line, idle high, driven from a flop
//   ready      FIFO not full
//   busy       frame on the line
//   empty      FIFO holds no entries
//   ovf        sticky: go arrived while full; cleared only by rst
// -----------------------------------------------------------------------------
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 ready,
  output logic                 busy,
  output logic                 empty,
  output logic                 ovf
);

  if (!cfg_ok(BAUD_DIV, DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH)) begin : g_bad_cfg
    $fatal(1, "uart_tx_ext: illegal parameter set");
  end

  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  tx_state_e            state;
  tx_state_e            state_nxt;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BAUD_W-1:0]    baud_nxt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 par_q;
  logic                 par_nxt;
  logic                 tx_q;
  logic                 tx_nxt;
  logic                 ovf_q;
  logic                 load;
  logic                 baud_wrap;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (go),
    .pop   (load),
    .din   (data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_wrap = (baud_cnt == BAUD_W'(BAUD_DIV - 1));

  // Next-state logic. tx_nxt is the level the line takes after the edge, so
  // every bit change is computed one cycle ahead and lands in tx_q.
  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_q;
    tx_nxt    = tx_q;
    load      = 1'b0;

    if (state != ST_IDLE) begin
      baud_nxt = baud_wrap ? '0 : baud_cnt + BAUD_W'(1);
    end

    case (state)
      ST_IDLE: begin
        load = !fifo_empty;
      end
      ST_START: begin
        if (baud_wrap) begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
        end
      end
      ST_DATA: begin
        if (baud_wrap) begin
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            bit_nxt = '0;
            if (PARITY != PAR_NONE) begin
              state_nxt = ST_PARITY;
              tx_nxt    = par_q;
            end else begin
              state_nxt = ST_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_wrap) begin
          state_nxt = ST_STOP;
          bit_nxt   = '0;
          tx_nxt    = 1'b1;
        end
      end
      ST_STOP: begin
        // bit_cnt counts stop bits here; the last stop cycle either chains
        // straight into the next start bit or returns to idle.
        if (baud_wrap) begin
          if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
            if (!fifo_empty) begin
              load = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        tx_nxt    = 1'b1;
      end
    endcase

    // Pop the FIFO head into the shift register and open a new frame.
    if (load) begin
      state_nxt = ST_START;
      baud_nxt  = '0;
      bit_nxt   = '0;
      shreg_nxt = fifo_dout;
      par_nxt   = parity_of(9'(fifo_dout), PARITY);
      tx_nxt    = 1'b0;
    end
  end

  // Control state: asynchronously reset, tx forced back to idle-high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx_q     <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      tx_q     <= tx_nxt;
      ovf_q    <= ovf_q | (go & fifo_full);
    end
  end

  // Payload and its parity bit are only read after a load, so no reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
    par_q <= par_nxt;
  end

  assign tx    = tx_q;
  assign ready = !fifo_full;
  assign busy  = (state != ST_IDLE);
  assign empty = fifo_empty;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_uart_tx_ext.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_ext
// Bench for uart_tx_ext. A cycle-level reference model of the default
// configuration (queue of characters, frame timeline, expected line level)
// runs alongside directed vector tables, multi-cycle corner sequences, a
// loopback receiver and a randomized push phase.
// -----------------------------------------------------------------------------
module tb_uart_tx_ext;

  localparam int BD    = 16;
  localparam int DB    = 8;
  localparam int FD    = 4;
  localparam int NBITS = 1 + DB + 1;
  localparam int FRAME = NBITS * BD;
  localparam int FR2   = (1 + 7 + 1 + 2) * BD;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [7:0] data;
  logic       tx, ready, busy, empty, ovf;

  logic       go_b;
  logic [6:0] data_b;
  logic       tx_e, ready_e, busy_e, empty_e, ovf_e;
  logic       tx_o, ready_o, busy_o, empty_o, ovf_o;

  int n_cmp = 0;
  int n_bad = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  uart_tx_ext #(.BAUD_DIV(BD), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .go(go), .data(data),
    .tx(tx), .ready(ready), .busy(busy), .empty(empty), .ovf(ovf));

  uart_tx_ext #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(FD)) dut_e (
    .clk(clk), .rst(rst), .go(go_b), .data(data_b),
    .tx(tx_e), .ready(ready_e), .busy(busy_e), .empty(empty_e), .ovf(ovf_e));

  uart_tx_ext #(.BAUD_DIV(BD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(FD)) dut_o (
    .clk(clk), .rst(rst), .go(go_b), .data(data_b),
    .tx(tx_o), .ready(ready_o), .busy(busy_o), .empty(empty_o), .ovf(ovf_o));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: characters waiting in a queue; a frame occupies the line
  // for FRAME cycles; a new frame starts when the line is free (or on its
  // last cycle) and something is queued. Pushes succeed while fewer than FD
  // characters wait.
  // ---------------------------------------------------------------------------
  logic [7:0] m_q[$];
  int         m_remain = 0;
  bit         m_ovf = 1'b0;
  bit         m_bits[NBITS];
  bit         m_pop, m_push;
  logic [7:0] m_head;
  int         m_tx_exp;

  always begin
    @(posedge clk);
    if (rst === 1'b1) begin
      m_q.delete();
      m_remain = 0;
      m_ovf    = 1'b0;
    end else begin
      m_pop  = (m_remain <= 1) && (m_q.size() > 0);
      m_push = (go === 1'b1) && (m_q.size() < FD);
      if ((go === 1'b1) && (m_q.size() >= FD)) m_ovf = 1'b1;
      if (m_pop) begin
        m_head = m_q.pop_front();
        m_bits[0] = 1'b0;
        for (int i = 0; i < DB; i++) m_bits[1 + i] = m_head[i];
        m_bits[NBITS - 1] = 1'b1;
        m_remain = FRAME;
      end else if (m_remain > 0) begin
        m_remain--;
      end
      if (m_push) m_q.push_back(data);
    end
    #1;
    if (model_on) begin
      m_tx_exp = (m_remain == 0) ? 1 : int'(m_bits[(FRAME - m_remain) / BD]);
      check("model_tx",    32'(tx),    m_tx_exp);
      check("model_busy",  32'(busy),  32'(m_remain != 0));
      check("model_ready", 32'(ready), 32'(m_q.size() < FD));
      check("model_empty", 32'(empty), 32'(m_q.size() == 0));
      check("model_ovf",   32'(ovf),   32'(m_ovf));
    end
  end

  // Behavioural receiver: waits for a start bit then samples mid-bit.
  task automatic rx_frame(output logic [7:0] b, output logic stop_bit);
    int waited;
    waited   = 0;
    b        = '0;
    stop_bit = 1'b0;
    while (tx !== 1'b0 && waited < 4 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    check("rx_start_seen", 32'(waited < 4 * FRAME), 1);
    if (waited < 4 * FRAME) begin
      repeat (BD / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(negedge clk);
        b[i] = tx;
      end
      repeat (BD) @(negedge clk);
      stop_bit = tx;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [9:0] frame;   // line level per bit time, index 0 = start bit
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] exp_even;
    logic [10:0] exp_odd;
    logic [7:0]  rxb;
    logic        rxs;
    int          busy_run;
    int          guard;
    int          noisy;
    logic [7:0]  s5_data[3];

    vecs[0] = '{8'h41, 10'b1010000010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};
    vecs[4] = '{8'h3C, 10'b1001111000};
    exp_even = 11'b11010101010;
    exp_odd  = 11'b11110101010;
    s5_data[0] = 8'h00;
    s5_data[1] = 8'h3C;
    s5_data[2] = 8'h5A;

    rst = 1'b1; go = 1'b0; data = '0; go_b = 1'b0; data_b = '0;
    model_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx",      32'(tx),      1);
    check("rst_ready",   32'(ready),   1);
    check("rst_busy",    32'(busy),    0);
    check("rst_empty",   32'(empty),   1);
    check("rst_ovf",     32'(ovf),     0);
    check("rst_tx_e",    32'(tx_e),    1);
    check("rst_ready_e", 32'(ready_e), 1);
    check("rst_empty_e", 32'(empty_e), 1);
    check("rst_ovf_e",   32'(ovf_e),   0);
    check("rst_tx_o",    32'(tx_o),    1);
    check("rst_ready_o", 32'(ready_o), 1);
    check("rst_empty_o", 32'(empty_o), 1);
    check("rst_ovf_o",   32'(ovf_o),   0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single characters, one frame each, sampled mid-bit.
    for (int r = 0; r < 5; r++) begin
      go = 1'b1; data = vecs[r].d;
      @(negedge clk);
      go = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_busy_rise", r), 32'(busy), 1);
      for (int j = 0; j <= FRAME; j++) begin
        if ((j % BD) == BD / 2 && j < FRAME)
          check($sformatf("vec%0d_bit%0d", r, j / BD), 32'(tx), 32'(vecs[r].frame[j / BD]));
        if (j == FRAME - 1) check($sformatf("vec%0d_busy_last", r), 32'(busy), 1);
        if (j == FRAME) begin
          check($sformatf("vec%0d_busy_fall", r), 32'(busy), 0);
          check($sformatf("vec%0d_tx_idle", r), 32'(tx), 1);
        end
        if (j < FRAME) @(negedge clk);
      end
      repeat (4) @(negedge clk);
    end

    // 7 data bits, two stop bits, even and odd parity on 0x55.
    go_b = 1'b1; data_b = 7'h55;
    @(negedge clk);
    go_b = 1'b0;
    @(negedge clk);
    for (int j = 0; j <= FR2; j++) begin
      if ((j % BD) == BD / 2 && j < FR2) begin
        check($sformatf("even_bit%0d", j / BD), 32'(tx_e), 32'(exp_even[j / BD]));
        check($sformatf("odd_bit%0d", j / BD),  32'(tx_o), 32'(exp_odd[j / BD]));
      end
      if (j == 0)       check("even_busy_rise", 32'(busy_e), 1);
      if (j == FR2 - 1) check("odd_busy_last",  32'(busy_o), 1);
      if (j == FR2) begin
        check("even_busy_fall", 32'(busy_e), 0);
        check("odd_busy_fall",  32'(busy_o), 0);
      end
      if (j < FR2) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // Six pushes on consecutive cycles into a 4-deep FIFO.
    busy_run = 0;
    for (int k = 0; k < 6; k++) begin
      go = 1'b1; data = 8'(k + 1);
      @(negedge clk);
      if (busy === 1'b1) busy_run++;
    end
    go = 1'b0;
    check("burst_ovf",   32'(ovf),   1);
    check("burst_ready", 32'(ready), 0);
    guard = 0;
    while (guard < 2000) begin
      @(negedge clk);
      guard++;
      if (busy !== 1'b1) break;
      busy_run++;
    end
    check("burst_busy_run", busy_run, 5 * FRAME);
    repeat (4) @(negedge clk);

    // Three queued characters, reset during the third data bit of frame 1.
    for (int k = 0; k < 3; k++) begin
      go = 1'b1; data = s5_data[k];
      @(negedge clk);
    end
    go = 1'b0;
    repeat (54) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx",    32'(tx),    1);
    check("async_rst_busy",  32'(busy),  0);
    check("async_rst_empty", 32'(empty), 1);
    check("async_rst_ovf",   32'(ovf),   0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    noisy = 0;
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) noisy++;
    end
    check("post_rst_quiet", noisy, 0);

    // Loopback: two characters decoded by the bench receiver.
    go = 1'b1; data = 8'd65;
    @(negedge clk);
    data = 8'd68;
    @(negedge clk);
    go = 1'b0;
    rx_frame(rxb, rxs);
    check("loop_char0", 32'(rxb), 65);
    check("loop_stop0", 32'(rxs), 1);
    rx_frame(rxb, rxs);
    check("loop_char1", 32'(rxb), 68);
    check("loop_stop1", 32'(rxs), 1);
    repeat (FRAME) @(negedge clk);

    // Randomized pushes: a sparse phase, then a dense one that overflows.
    for (int c = 0; c < 6000; c++) begin
      go   = ($urandom_range(0, 999) < ((c < 3000) ? 8 : 40));
      data = 8'($urandom);
      @(negedge clk);
    end
    go = 1'b0;
    repeat (FRAME * (FD + 2)) @(negedge clk);
    check("drain_empty", 32'(empty), 1);
    check("drain_busy",  32'(busy),  0);
    check("drain_tx",    32'(tx),    1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_ext.md
# uart_tx_ext

Parametrised UART transmitter with an input FIFO, configurable data length, parity and stop bits. It replaces the single-byte `tx` serialiser in the `toy` MCU and in the UART benches. The requester can queue several characters without polling `ready` between bytes. Frames are sent back-to-back with no idle gap while the FIFO is non-empty.

## Interface
- `BAUD_DIV`, 16: clk cycles per bit; ≥2.
- `DATA_BITS`, 8: payload bits per frame; 5..9.
- `PARITY`, 0: 0 none, 1 odd, 2 even. Value 3 is illegal and must fail elaboration.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: entries; power of 2, ≥2.

Ports:
- `clk`, input, 1: the single clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `go`, input, 1: push strobe, one cycle per character.
- `data`, input, DATA_BITS: character to push; sampled with `go`.
- `tx`, output, 1: serial line, idle high.
- `ready`, output, 1: FIFO not full.
- `busy`, output, 1: frame on the line (state ≠ IDLE).
- `empty`, output, 1: FIFO holds no entries.
- `ovf`, output, 1: sticky; set when `go` arrives while full. Cleared only by `rst`.

## Operation
- Reset values: `tx`=1, `ready`=1, `busy`=0, `empty`=1, `ovf`=0. FIFO pointers, count, baud counter and bit counter are all 0; state is IDLE.
- Push rules:
  - `go`=1 with `ready`=1 writes `data` at the rising edge.
  - `go`=1 with `ready`=0 drops the data and sets `ovf`.
  - Acceptance depends only on "full" before the edge. A pop on the same edge does not free a slot for that push.
- State machine: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE or START.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register, compute the parity bit, and go to START.
  - START: `tx`=0 for BAUD_DIV cycles.
  - DATA: DATA_BITS bits, LSB first, BAUD_DIV cycles each.
  - PARITY: odd mode makes the total count of ones in data plus parity odd; even mode makes it even.
  - STOP: `tx`=1 for STOP_BITS×BAUD_DIV cycles. On the last stop cycle:
    - if the FIFO is non-empty, pop and go straight to START;
    - otherwise go to IDLE.
- `tx` is driven from a register; no combinational path from `go` or `data` to `tx`.
- Baud counter runs 0..BAUD_DIV−1; the bit advances on wrap.
- Bit counter is $clog2(DATA_BITS+1) bits wide.
- FIFO count is $clog2(FIFO_DEPTH)+1 bits wide; pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: `tx` returns to 1 asynchronously, the frame is aborted and queued data is discarded.

## Timing
- Latency: `go` accepted at edge N with the FIFO empty and IDLE:
  - pop at edge N+1;
  - `tx` falls after edge N+1;
  - `busy`=1 from edge N+1.
- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_DIV cycles. Default: 160 cycles.
- Back-to-back frames: the next start bit begins on the cycle right after the last stop-bit cycle.
- `ready`, `empty` and `busy` are registered. They reflect push/pop results one edge after the event.
- Simultaneous push and pop when not full: count unchanged, both happen.

## Structure
- Shared package `uart_pkg`:
  - parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - state encoding for the transmitter;
  - parameter-legality check macro/function.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with async reset.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, din, dout, full, empty.
- Serialiser FSM, baud counter and parity logic live in the top module.

## Test plan
1. Defaults, push 0x41 once → `tx` low 16 cycles from one cycle after the pop, then 1,0,0,0,0,0,1,0 at 16 cycles each, then high. `busy` falls 160 cycles after it rose.
2. Defaults, `go` on 6 consecutive cycles with 0x01..0x06:
   - 0x01..0x05 accepted; 6th dropped;
   - `ovf`=1, `ready`=0 for one frame;
   - five frames in 800 contiguous cycles, no idle-high gap.
3. DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x55 → bits 1,0,1,0,1,0,1, parity 0, two stop bits; frame 176 cycles.
4. Same configuration with PARITY=1 → parity bit 1; all other bits identical to scenario 3.
5. Defaults, queue 3 bytes, assert `rst` during the 3rd data bit of frame 1:
   - `tx`=1 immediately, `busy`=0, `empty`=1, `ovf`=0;
   - no further frames after release.
6. Loopback into the existing `rx` at BAUD_DIV=16, push 65 then 68 → receiver outputs 65 then 68, no framing error.
